// File: rtl/i2s_master_rx.sv
// I2S bus-master receiver: generates sck/ws from clk_i, captures left/right words from sd_i,
// and presents stereo pairs on a valid/ready handshake. Optional macro I2S_RX_SYNC_EN adds an sd_i synchronizer.
module i2s_master_rx #(
  parameter int AUDIO_DW = 8,
  parameter int CLK_DIV  = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  output logic                sck_o,
  output logic                ws_o,
  input  logic                sd_i,
  output logic [AUDIO_DW-1:0] l_data_o,
  output logic [AUDIO_DW-1:0] r_data_o,
  output logic                valid_o,
  input  logic                ready_i,
  output logic                overrun_o
);

  localparam int DIVW = $clog2(CLK_DIV);
  localparam int KW   = $clog2(2 * AUDIO_DW);
  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(CLK_DIV - 1);
  localparam logic [KW-1:0]   K_LAST   = KW'(2 * AUDIO_DW - 1);
  localparam logic [KW-1:0]   K_HALF   = KW'(AUDIO_DW);

  logic                run_q, run_d;
  logic [DIVW-1:0]     div_q, div_d;
  logic                sck_q, sck_d;
  logic [KW-1:0]       k_q, k_d;
  logic                ws_q, ws_d;
  logic [AUDIO_DW-1:0] l_sh_q, l_sh_d;
  logic [AUDIO_DW-1:0] r_sh_q, r_sh_d;
  logic                left_ok_q, left_ok_d;
  logic                comp_q, comp_d;
  logic [AUDIO_DW-1:0] l_data_q, l_data_d;
  logic [AUDIO_DW-1:0] r_data_q, r_data_d;
  logic                valid_q, valid_d;
  logic                ovr_q, ovr_d;

  logic sample_ev;
  logic sd_smp;

`ifdef I2S_RX_SYNC_EN
  logic sd_s1_q, sd_s2_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sd_s1_q <= 1'b0;
      sd_s2_q <= 1'b0;
    end else begin
      sd_s1_q <= sd_i;
      sd_s2_q <= sd_s1_q;
    end
  end

  // Two clk into the high half the synchronizer holds the value present at the rising edge.
  assign sd_smp    = sd_s2_q;
  assign sample_ev = sck_q && (div_q == DIVW'(1));
`else
  assign sd_smp    = sd_i;
  assign sample_ev = !sck_q && (div_q == DIV_LAST);
`endif

  always_comb begin
    run_d     = run_q;
    div_d     = div_q;
    sck_d     = sck_q;
    k_d       = k_q;
    ws_d      = ws_q;
    l_sh_d    = l_sh_q;
    r_sh_d    = r_sh_q;
    left_ok_d = left_ok_q;
    comp_d    = 1'b0;
    l_data_d  = l_data_q;
    r_data_d  = r_data_q;
    valid_d   = valid_q;
    ovr_d     = ovr_q;

    if (!en_i) begin
      run_d     = 1'b0;
      div_d     = '0;
      sck_d     = 1'b0;
      k_d       = '0;
      ws_d      = 1'b0;
      l_sh_d    = '0;
      r_sh_d    = '0;
      left_ok_d = 1'b0;
      valid_d   = 1'b0;
      ovr_d     = 1'b0;
    end else begin
      if (!run_q) begin
        run_d = 1'b1;
      end else begin
        div_d = (div_q == DIV_LAST) ? '0 : div_q + DIVW'(1);
        if (div_q == DIV_LAST) begin
          sck_d = !sck_q;
          if (sck_q) begin
            k_d  = (k_q == K_LAST) ? '0 : k_q + KW'(1);
            ws_d = (k_d >= K_HALF);
          end
        end
        // Period k carries frame bit k-1: periods 1..DW are left, the rest right.
        if (sample_ev) begin
          if (k_q != '0 && k_q <= K_HALF) begin
            l_sh_d = {l_sh_q[AUDIO_DW-2:0], sd_smp};
            if (k_q == K_HALF) left_ok_d = 1'b1;
          end else begin
            r_sh_d = {r_sh_q[AUDIO_DW-2:0], sd_smp};
          end
          if (k_q == '0 && left_ok_q) begin
            comp_d    = 1'b1;
            left_ok_d = 1'b0;
          end
        end
      end

      if (comp_q) begin
        if (!valid_q || ready_i) begin
          l_data_d = l_sh_q;
          r_data_d = r_sh_q;
          valid_d  = 1'b1;
        end else begin
          ovr_d = 1'b1;
        end
      end else if (valid_q && ready_i) begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      run_q     <= 1'b0;
      div_q     <= '0;
      sck_q     <= 1'b0;
      k_q       <= '0;
      ws_q      <= 1'b0;
      l_sh_q    <= '0;
      r_sh_q    <= '0;
      left_ok_q <= 1'b0;
      comp_q    <= 1'b0;
      l_data_q  <= '0;
      r_data_q  <= '0;
      valid_q   <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      run_q     <= run_d;
      div_q     <= div_d;
      sck_q     <= sck_d;
      k_q       <= k_d;
      ws_q      <= ws_d;
      l_sh_q    <= l_sh_d;
      r_sh_q    <= r_sh_d;
      left_ok_q <= left_ok_d;
      comp_q    <= comp_d;
      l_data_q  <= l_data_d;
      r_data_q  <= r_data_d;
      valid_q   <= valid_d;
      ovr_q     <= ovr_d;
    end
  end

  assign sck_o     = sck_q;
  assign ws_o      = ws_q;
  assign l_data_o  = l_data_q;
  assign r_data_o  = r_data_q;
  assign valid_o   = valid_q;
  assign overrun_o = ovr_q;

endmodule
